xext_bridge: RTL and testbench

//  Target-side responder for the external address window: converts a single-cycle ext_sel access from the

---
 rtl/xext_bridge.sv | 136 +++++++++++++
 tb/tb_xext_bridge.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/xext_bridge.sv
// External-window bridge: turns a one-cycle ext_sel access into a valid/ready request on the external bus.
// Optional REQ-phase timeout abort is compiled in with `define XEXT_TIMEOUT_EN.
module xext_bridge #(
    parameter int EXT_ADDR_W     = 12,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ext_sel,
    input  logic                  we,
    input  logic [EXT_ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]     data_in,
    output logic [DATA_W-1:0]     ext_data_to_rd,
    output logic                  ext_busy,
    output logic                  ext_err,
    output logic                  m_valid,
    output logic [EXT_ADDR_W-1:0] m_addr,
    output logic                  m_we,
    output logic [DATA_W-1:0]     m_wdata,
    input  logic                  m_ready,
    input  logic [DATA_W-1:0]     m_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic                  m_valid_reg;
    logic [EXT_ADDR_W-1:0] m_addr_reg;
    logic                  m_we_reg;
    logic [DATA_W-1:0]     m_wdata_reg;
    logic [DATA_W-1:0]     rd_data_reg;

    logic accept;
    logic complete;
    logic timeout_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (ext_sel) state_next = REQ;
            REQ:     if (m_ready || timeout_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // rst gates ext_busy so the core is released in the same cycle reset rises, even with ext_sel high.
    always_comb begin
        accept   = 1'b0;
        complete = 1'b0;
        ext_busy = 1'b0;
        case (state_reg)
            IDLE: begin
                accept   = ext_sel;
                ext_busy = ext_sel & ~rst;
            end
            REQ: begin
                complete = m_ready;
                ext_busy = ~rst;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_reg <= 1'b0;
            m_addr_reg  <= '0;
            m_we_reg    <= 1'b0;
            m_wdata_reg <= '0;
            rd_data_reg <= '0;
        end else if (accept) begin
            m_valid_reg <= 1'b1;
            m_addr_reg  <= addr;
            m_we_reg    <= we;
            m_wdata_reg <= data_in;
        end else if (complete) begin
            m_valid_reg <= 1'b0;
            if (!m_we_reg) rd_data_reg <= m_rdata;
        end else if (timeout_hit) begin
            m_valid_reg <= 1'b0;
            rd_data_reg <= '1;
        end
    end

`ifdef XEXT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             err_reg;

    // m_ready in the final REQ cycle takes priority over the abort.
    assign timeout_hit = (state_reg == REQ) && !m_ready
                      && (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
            err_reg <= 1'b0;
        end else if (accept) begin
            cnt_reg <= '0;
            err_reg <= 1'b0;
        end else if (timeout_hit) begin
            err_reg <= 1'b1;
        end else if (state_reg == REQ && !m_ready) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign ext_err = err_reg;
`else
    assign timeout_hit = 1'b0;
    assign ext_err     = 1'b0;
`endif

    assign m_valid        = m_valid_reg;
    assign m_addr         = m_addr_reg;
    assign m_we           = m_we_reg;
    assign m_wdata        = m_wdata_reg;
    assign ext_data_to_rd = rd_data_reg;

endmodule

// File: tb/tb_xext_bridge.sv
// Self-checking bench for xext_bridge: directed cases then random accesses against a transaction-level model.
// Timeout cases run only when XEXT_TIMEOUT_EN is defined.
module tb_xext_bridge;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ext_sel;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_in;
    logic [DW-1:0] ext_data_to_rd;
    logic          ext_busy;
    logic          ext_err;
    logic          m_valid;
    logic [AW-1:0] m_addr;
    logic          m_we;
    logic [DW-1:0] m_wdata;
    logic          m_ready;
    logic [DW-1:0] m_rdata;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] model_rd;
    logic          model_err;

    always #5 clk = ~clk;

    xext_bridge #(
        .EXT_ADDR_W    (AW),
        .DATA_W        (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ext_sel       (ext_sel),
        .we            (we),
        .addr          (addr),
        .data_in       (data_in),
        .ext_data_to_rd(ext_data_to_rd),
        .ext_busy      (ext_busy),
        .ext_err       (ext_err),
        .m_valid       (m_valid),
        .m_addr        (m_addr),
        .m_we          (m_we),
        .m_wdata       (m_wdata),
        .m_ready       (m_ready),
        .m_rdata       (m_rdata)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One access: 'waits' REQ cycles without m_ready before m_ready rises. Entered and left at posedge+1.
    task automatic do_access(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input int waits, input logic [DW-1:0] rdat, input bit hold);
        int  limit;
        bit  timed_out;
        int  vcnt;
        int  bcnt;
        limit     = waits;
        timed_out = 1'b0;
        vcnt      = 0;
        bcnt      = 0;
`ifdef XEXT_TIMEOUT_EN
        if (waits >= TO) begin
            timed_out = 1'b1;
            limit     = TO - 1;
        end
`endif
        ext_sel = 1'b1;
        we      = w;
        addr    = a;
        data_in = d;
        m_ready = 1'b0;
        m_rdata = $urandom;
        #1;
        chk("idle_busy", 32'(ext_busy), 32'd1);
        bcnt += int'(ext_busy);
        @(posedge clk); #1;
        model_err = 1'b0;
        for (int k = 0; k <= limit; k++) begin
            m_ready = (k == waits);
            m_rdata = (k == waits) ? rdat : $urandom;
            #1;
            chk("req_valid", 32'(m_valid), 32'd1);
            chk("req_addr",  32'(m_addr),  32'(a));
            chk("req_we",    32'(m_we),    32'(w));
            chk("req_wdata", m_wdata, d);
            chk("req_rd",    ext_data_to_rd, model_rd);
            chk("req_err",   32'(ext_err), 32'(model_err));
            vcnt += int'(m_valid);
            bcnt += int'(ext_busy);
            @(posedge clk); #1;
        end
        if (timed_out) begin
            model_rd  = '1;
            model_err = 1'b1;
        end else if (!w) begin
            model_rd = rdat;
        end
        m_ready = 1'b1;
        m_rdata = $urandom;
        ext_sel = hold;
        #1;
        chk("resp_valid", 32'(m_valid), 32'd0);
        chk("resp_busy",  32'(ext_busy), 32'd0);
        chk("resp_rd",    ext_data_to_rd, model_rd);
        chk("resp_err",   32'(ext_err), 32'(model_err));
        chk("valid_cycles", 32'(vcnt), 32'(limit + 1));
        chk("busy_cycles",  32'(bcnt), 32'(limit + 2));
        @(posedge clk); #1;
        m_ready = 1'b0;
        chk("post_valid", 32'(m_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; ext_sel = 1'b0; we = 1'b0; addr = '0; data_in = '0;
        m_ready = 1'b0; m_rdata = '0;
        model_rd = '0; model_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_busy",  32'(ext_busy), 32'd0);
        chk("rst_addr",  32'(m_addr), 32'd0);
        chk("rst_wdata", m_wdata, 32'd0);
        chk("rst_rd",    ext_data_to_rd, 32'd0);
        chk("rst_err",   32'(ext_err), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Write with one wait state; read data must remain untouched.
        do_access(1'b1, 12'h010, 32'hA5A5_A5A5, 1, 32'hDEAD_BEEF, 1'b0);
        // Zero-wait read.
        do_access(1'b0, 12'h020, 32'h0, 0, 32'h1234_5678, 1'b0);
        // Back-to-back with ext_sel held through RESP.
        do_access(1'b0, 12'h004, 32'h0, 0, 32'h0BAD_F00D, 1'b1);
        do_access(1'b1, 12'h008, 32'h5555_AAAA, 2, 32'h0, 1'b0);

`ifdef XEXT_TIMEOUT_EN
        do_access(1'b0, 12'h030, 32'h0, 50, 32'h0, 1'b0);
        do_access(1'b1, 12'h034, 32'h1111_2222, 0, 32'h0, 1'b0);
        do_access(1'b0, 12'h038, 32'h0, TO - 1, 32'hCAFE_0001, 1'b0);
`endif

        for (int i = 0; i < 24; i++) begin
            do_access(1'($urandom), 12'($urandom), $urandom, int'($urandom_range(0, 6)),
                      $urandom, 1'($urandom));
        end
        ext_sel = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset while the request is outstanding.
        ext_sel = 1'b1; we = 1'b0; addr = 12'h0FF; data_in = 32'h7777_7777; m_ready = 1'b0;
        @(posedge clk); #1;
        chk("mid_valid", 32'(m_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_valid", 32'(m_valid), 32'd0);
        chk("async_busy",  32'(ext_busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ext_sel = 1'b0;
        model_rd = '0;
        model_err = 1'b0;
        #1;
        chk("rel_valid", 32'(m_valid), 32'd0);
        chk("rel_busy",  32'(ext_busy), 32'd0);
        chk("rel_addr",  32'(m_addr), 32'd0);
        chk("rel_we",    32'(m_we), 32'd0);
        chk("rel_wdata", m_wdata, 32'd0);
        chk("rel_rd",    ext_data_to_rd, model_rd);
        chk("rel_err",   32'(ext_err), 32'(model_err));
        @(posedge clk); #1;
        do_access(1'b0, 12'h044, 32'h0, 1, 32'h600D_CAFE, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
